// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serdes_pkg
// Description : Shared constants and types for the 8b/10b transmit scheduler.
//               K28_5 is the comma used for alignment and idle fill, K28_0 is
//               the clock-compensation skip symbol.
// Revision    : 1.0 - initial release
// ============================================================================
package serdes_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sym_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : sym_slot_timer
// Description : Free-running symbol slot counter (0..SYM_PERIOD-1, wrapping).
//               A synchronous restart holds the count at 0, so the first cycle
//               after restart drops is a slot cycle.
// Ports       : i_Clk      - clock
//               i_Rst_n    - asynchronous active-low reset
//               i_Restart  - synchronous restart, forces count to 0
//               o_Slot     - high while the count is 0
// Revision    : 1.0 - initial release
// ============================================================================
module sym_slot_timer #(
    parameter int SYM_PERIOD = 10
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Restart,
    output logic o_Slot
);

    localparam int              CW        = $clog2(SYM_PERIOD);
    localparam logic [CW-1:0]   C_LAST    = CW'(SYM_PERIOD - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q <= '0;
        end else if (i_Restart || (cnt_q == C_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign o_Slot = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/serdes_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : serdes_tx_sched
// Description : Word-rate transmit scheduler in front of the 8b/10b encoder.
//               Brings the link up with ALIGN_COUNT K28.5 commas, then shares
//               one symbol per slot between a control requester (sent as
//               K-characters) and a data requester (D-characters), filling
//               empty slots with K28.5 idles. Control may win at most
//               MAX_CTL_BURST consecutive slots while data is waiting.
// Config      : SERDES_SCHED_SKIP_EN - when defined, every SKIP_INTERVAL-th
//               active slot carries a K28.0 skip symbol and no grant.
// Ports       : i_Clk, i_Rst_n           - clock, async active-low reset
//               i_Link_En                - link enable; low forces OFF
//               i_Ctl_Valid/Data, o_Ctl_Ready - control requester
//               i_Dat_Valid/Data, o_Dat_Ready - data requester
//               o_Sym_Valid/Data/K       - registered symbol, one strobe/slot
//               o_Link_Up                - high while ACTIVE
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_tx_sched
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int SYM_PERIOD    = 10,
    parameter int ALIGN_COUNT   = 4,
    parameter int SKIP_INTERVAL = 256,
    parameter int MAX_CTL_BURST = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Link_En,
    input  logic                  i_Ctl_Valid,
    input  logic [DATA_WIDTH-1:0] i_Ctl_Data,
    output logic                  o_Ctl_Ready,
    input  logic                  i_Dat_Valid,
    input  logic [DATA_WIDTH-1:0] i_Dat_Data,
    output logic                  o_Dat_Ready,
    output logic                  o_Sym_Valid,
    output logic [DATA_WIDTH-1:0] o_Sym_Data,
    output logic                  o_Sym_K,
    output logic                  o_Link_Up
);

    localparam int            AW          = $clog2(ALIGN_COUNT + 1);
    localparam logic [AW-1:0] ALIGN_LAST  = AW'(ALIGN_COUNT - 1);
    localparam int            BW          = $clog2(MAX_CTL_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX   = BW'(MAX_CTL_BURST);

    sched_state_t          state_q;
    logic [AW-1:0]         align_cnt_q;
    logic [BW-1:0]         burst_q;
    logic [BW-1:0]         burst_d;
    logic                  sym_valid_q;
    logic [DATA_WIDTH-1:0] sym_data_q;
    logic                  sym_k_q;
    logic                  link_up_q;

    logic w_slot_strobe;
    logic w_slot;
    logic w_active_slot;
    logic w_skip;
    logic w_burst_full;
    logic w_ctl_win;
    logic w_grant_ok;
    logic w_ctl_grant;
    logic w_dat_grant;

    // Counter is parked at 0 while OFF or disabled, so the cycle right after
    // OFF->ALIGN is the first slot cycle.
    sym_slot_timer #(
        .SYM_PERIOD (SYM_PERIOD)
    ) u_slot_timer (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .i_Restart ((state_q == OFF) || !i_Link_En),
        .o_Slot    (w_slot_strobe)
    );

    assign w_slot        = w_slot_strobe && i_Link_En;
    assign w_active_slot = w_slot && (state_q == ACTIVE);

`ifdef SERDES_SCHED_SKIP_EN
    localparam int            SW        = $clog2(SKIP_INTERVAL);
    localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_INTERVAL - 1);

    logic [SW-1:0] skip_cnt_q;
    logic [SW-1:0] skip_cnt_d;

    always_comb begin
        skip_cnt_d = skip_cnt_q;
        if (!i_Link_En || (state_q != ACTIVE)) begin
            skip_cnt_d = '0;
        end else if (w_active_slot) begin
            skip_cnt_d = (skip_cnt_q == SKIP_LAST) ? '0 : skip_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            skip_cnt_q <= '0;
        end else begin
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign w_skip = w_active_slot && (skip_cnt_q == SKIP_LAST);
`else
    logic w_unused_skip_cfg;
    assign w_unused_skip_cfg = (SKIP_INTERVAL > 1);
    assign w_skip            = 1'b0;
`endif

    // Control loses only when data is waiting and control has used up its
    // burst allowance; readys are decided from valids, never from each other.
    assign w_burst_full = (burst_q == BURST_MAX);
    assign w_ctl_win    = i_Ctl_Valid && !(i_Dat_Valid && w_burst_full);
    assign w_grant_ok   = w_active_slot && !w_skip;
    assign w_ctl_grant  = w_grant_ok && w_ctl_win;
    assign w_dat_grant  = w_grant_ok && i_Dat_Valid && !w_ctl_win;

    assign o_Ctl_Ready  = w_ctl_grant;
    assign o_Dat_Ready  = w_dat_grant;

    // A skip slot with data waiting leaves the burst count untouched, so the
    // stalled requesters resume exactly where they were.
    always_comb begin
        burst_d = burst_q;
        if (!i_Link_En || (state_q != ACTIVE)) begin
            burst_d = '0;
        end else if (w_slot) begin
            if (!i_Dat_Valid || w_dat_grant) begin
                burst_d = '0;
            end else if (w_ctl_grant && !w_burst_full) begin
                burst_d = burst_q + BW'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= OFF;
            align_cnt_q <= '0;
            burst_q     <= '0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= '0;
            sym_k_q     <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            sym_valid_q <= 1'b0;
            burst_q     <= burst_d;
            if (!i_Link_En) begin
                state_q     <= OFF;
                align_cnt_q <= '0;
                link_up_q   <= 1'b0;
            end else begin
                case (state_q)
                    OFF: begin
                        state_q     <= ALIGN;
                        align_cnt_q <= '0;
                    end
                    ALIGN: begin
                        if (w_slot) begin
                            sym_valid_q <= 1'b1;
                            sym_data_q  <= DATA_WIDTH'(K28_5);
                            sym_k_q     <= 1'b1;
                            if (align_cnt_q == ALIGN_LAST) begin
                                state_q     <= ACTIVE;
                                link_up_q   <= 1'b1;
                                align_cnt_q <= '0;
                            end else begin
                                align_cnt_q <= align_cnt_q + AW'(1);
                            end
                        end
                    end
                    ACTIVE: begin
                        if (w_slot) begin
                            sym_valid_q <= 1'b1;
                            if (w_skip) begin
                                sym_data_q <= DATA_WIDTH'(K28_0);
                                sym_k_q    <= 1'b1;
                            end else if (w_ctl_grant) begin
                                sym_data_q <= i_Ctl_Data;
                                sym_k_q    <= 1'b1;
                            end else if (w_dat_grant) begin
                                sym_data_q <= i_Dat_Data;
                                sym_k_q    <= 1'b0;
                            end else begin
                                sym_data_q <= DATA_WIDTH'(K28_5);
                                sym_k_q    <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q   <= OFF;
                        link_up_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_Sym_Valid = sym_valid_q;
    assign o_Sym_Data  = sym_data_q;
    assign o_Sym_K     = sym_k_q;
    assign o_Link_Up   = link_up_q;

endmodule
`default_nettype wire

// File: tb/tb_serdes_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdes_tx_sched
// Description : Directed self-checking bench for serdes_tx_sched with
//               SYM_PERIOD=10, ALIGN_COUNT=4, SKIP_INTERVAL=4,
//               MAX_CTL_BURST=4. Skip expectations follow
//               SERDES_SCHED_SKIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdes_tx_sched;

    localparam int SYM_PERIOD    = 10;
    localparam int ALIGN_COUNT   = 4;
    localparam int SKIP_INTERVAL = 4;
    localparam int MAX_CTL_BURST = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       link_en   = 1'b0;
    logic       ctl_valid = 1'b0;
    logic [7:0] ctl_data  = 8'h00;
    logic       dat_valid = 1'b0;
    logic [7:0] dat_data  = 8'h00;
    logic       ctl_ready;
    logic       dat_ready;
    logic       sym_valid;
    logic [7:0] sym_data;
    logic       sym_k;
    logic       link_up;

    int tests    = 0;
    int fails    = 0;
    int act_slots = 0;

    always #5 clk = ~clk;

    serdes_tx_sched #(
        .DATA_WIDTH    (8),
        .SYM_PERIOD    (SYM_PERIOD),
        .ALIGN_COUNT   (ALIGN_COUNT),
        .SKIP_INTERVAL (SKIP_INTERVAL),
        .MAX_CTL_BURST (MAX_CTL_BURST)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Link_En   (link_en),
        .i_Ctl_Valid (ctl_valid),
        .i_Ctl_Data  (ctl_data),
        .o_Ctl_Ready (ctl_ready),
        .i_Dat_Valid (dat_valid),
        .i_Dat_Data  (dat_data),
        .o_Dat_Ready (dat_ready),
        .o_Sym_Valid (sym_valid),
        .o_Sym_Data  (sym_data),
        .o_Sym_K     (sym_k),
        .o_Link_Up   (link_up)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until a symbol strobe is seen; n = cycles taken, -1 on timeout.
    task automatic wait_sym(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sym_valid && n < 40);
        if (!sym_valid) n = -1;
    endtask

    // From a strobe cycle, advance to the next slot cycle (9 cycles) and count
    // cycles in between that show a strobe or a ready.
    task automatic to_slot(output int stray);
        stray = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i < 9 && (sym_valid || ctl_ready || dat_ready)) stray++;
        end
    endtask

    function automatic bit is_skip(input int n);
`ifdef SERDES_SCHED_SKIP_EN
        return (n % SKIP_INTERVAL) == (SKIP_INTERVAL - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        int cnt;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({sym_valid, sym_data, sym_k, link_up, ctl_ready, dat_ready} !== 13'h0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h k=%b up=%b cr=%b dr=%b, want all 0",
                     sym_valid, sym_data, sym_k, link_up, ctl_ready, dat_ready);
        end
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            tick();
            if (sym_valid || link_up) cnt++;
        end
        tests++;
        if (cnt != 0) begin
            fails++;
            $display("FAIL off_quiet: got %0d active cycles, want 0", cnt);
        end
    endtask

    // Four commas with the given first gap, link_up only on the last one.
    task automatic align_seq(input string tag);
        int n;
        for (int k = 0; k < ALIGN_COUNT; k++) begin
            wait_sym(n);
            tests++;
            if (n != ((k == 0) ? 2 : SYM_PERIOD)) begin
                fails++;
                $display("FAIL %s_gap%0d: got %0d cycles, want %0d", tag, k, n,
                         (k == 0) ? 2 : SYM_PERIOD);
            end
            tests++;
            if (sym_data !== 8'hBC || sym_k !== 1'b1) begin
                fails++;
                $display("FAIL %s_comma%0d: got %h/K=%b, want bc/K=1", tag, k, sym_data, sym_k);
            end
            tests++;
            if (link_up !== (k == ALIGN_COUNT - 1)) begin
                fails++;
                $display("FAIL %s_linkup%0d: got %b, want %b", tag, k, link_up,
                         (k == ALIGN_COUNT - 1));
            end
        end
        act_slots = 0;
    endtask

    task automatic test_bringup();
        link_en = 1'b1;
        align_seq("bringup");
    endtask

    task automatic test_idle();
        int stray;
        logic [7:0] exp_d;
        for (int s = 0; s < 4; s++) begin
            to_slot(stray);
            tests++;
            if (stray != 0 || ctl_ready || dat_ready) begin
                fails++;
                $display("FAIL idle_quiet%0d: got stray=%0d cr=%b dr=%b, want 0", s, stray,
                         ctl_ready, dat_ready);
            end
            tick();
            exp_d = is_skip(act_slots) ? 8'h1C : 8'hBC;
            tests++;
            if (sym_valid !== 1'b1 || sym_data !== exp_d || sym_k !== 1'b1) begin
                fails++;
                $display("FAIL idle_sym%0d: got v=%b %h/K=%b, want v=1 %h/K=1", s, sym_valid,
                         sym_data, sym_k, exp_d);
            end
            act_slots++;
        end
    endtask

    // Both requesters always valid: control wins while burst < MAX_CTL_BURST.
    task automatic test_arbitration(input int nslots);
        int stray;
        int burst;
        logic [7:0] exp_d;
        logic exp_k, exp_cr, exp_dr, cr, dr;
        burst     = 0;
        ctl_data  = 8'h30;
        dat_data  = 8'hA0;
        ctl_valid = 1'b1;
        dat_valid = 1'b1;
        for (int s = 0; s < nslots; s++) begin
            to_slot(stray);
            tests++;
            if (stray != 0) begin
                fails++;
                $display("FAIL arb_quiet%0d: got %0d stray cycles, want 0", s, stray);
            end
            exp_cr = 1'b0;
            exp_dr = 1'b0;
            if (is_skip(act_slots)) begin
                exp_d = 8'h1C; exp_k = 1'b1;
            end else if (burst < MAX_CTL_BURST) begin
                exp_cr = 1'b1; exp_d = ctl_data; exp_k = 1'b1;
            end else begin
                exp_dr = 1'b1; exp_d = dat_data; exp_k = 1'b0;
            end
            cr = ctl_ready;
            dr = dat_ready;
            tests++;
            if (cr !== exp_cr || dr !== exp_dr) begin
                fails++;
                $display("FAIL arb_ready%0d: got cr=%b dr=%b, want cr=%b dr=%b", s, cr, dr,
                         exp_cr, exp_dr);
            end
            tick();
            tests++;
            if (sym_valid !== 1'b1 || sym_data !== exp_d || sym_k !== exp_k) begin
                fails++;
                $display("FAIL arb_sym%0d: got v=%b %h/K=%b, want v=1 %h/K=%b", s, sym_valid,
                         sym_data, sym_k, exp_d, exp_k);
            end
            if (cr) ctl_data = ctl_data + 8'h01;
            if (dr) dat_data = dat_data + 8'h01;
            if (exp_dr) burst = 0;
            else if (exp_cr && burst < MAX_CTL_BURST) burst++;
            act_slots++;
        end
        ctl_valid = 1'b0;
        dat_valid = 1'b0;
    endtask

    task automatic test_link_drop();
        int n;
        int cnt;
        link_en = 1'b0;
        tick();
        tests++;
        if (link_up !== 1'b0 || sym_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_active: got up=%b v=%b, want 0 0", link_up, sym_valid);
        end
        link_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_sym(n);
            tests++;
            if (n != ((k == 0) ? 2 : SYM_PERIOD) || sym_data !== 8'hBC) begin
                fails++;
                $display("FAIL drop_partial%0d: got gap=%0d %h, want gap=%0d bc", k, n, sym_data,
                         (k == 0) ? 2 : SYM_PERIOD);
            end
        end
        link_en = 1'b0;
        cnt = 0;
        repeat (30) begin
            tick();
            if (sym_valid || link_up) cnt++;
        end
        tests++;
        if (cnt != 0) begin
            fails++;
            $display("FAIL drop_align_quiet: got %0d active cycles, want 0", cnt);
        end
        link_en = 1'b1;
        align_seq("realign");
    endtask

    task automatic test_data_latency();
        int stray;
        bit done;
        done      = 1'b0;
        ctl_valid = 1'b0;
        dat_valid = 1'b1;
        dat_data  = 8'hA5;
        for (int s = 0; s < 3 && !done; s++) begin
            to_slot(stray);
            tests++;
            if (stray != 0) begin
                fails++;
                $display("FAIL lat_quiet%0d: got %0d stray cycles, want 0", s, stray);
            end
            if (is_skip(act_slots)) begin
                tests++;
                if (dat_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL lat_skip_ready: got %b, want 0", dat_ready);
                end
                tick();
            end else begin
                tests++;
                if (dat_ready !== 1'b1 || ctl_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL lat_ready: got dr=%b cr=%b, want 1 0", dat_ready, ctl_ready);
                end
                tick();
                tests++;
                if (sym_valid !== 1'b1 || sym_data !== 8'hA5 || sym_k !== 1'b0) begin
                    fails++;
                    $display("FAIL lat_sym: got v=%b %h/K=%b, want v=1 a5/K=0", sym_valid,
                             sym_data, sym_k);
                end
                tests++;
                if (dat_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL lat_ready_after: got %b, want 0", dat_ready);
                end
                done = 1'b1;
            end
            act_slots++;
        end
        dat_valid = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL lat_grant: got no data grant in 3 slots, want one");
        end
    endtask

    task automatic test_async_reset();
        int stray;
        dat_valid = 1'b1;
        dat_data  = 8'h5A;
        to_slot(stray);
        tick();
        act_slots++;
        tests++;
        if (link_up !== 1'b1 || sym_valid !== 1'b1) begin
            fails++;
            $display("FAIL arst_pre: got up=%b v=%b, want 1 1", link_up, sym_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({sym_valid, sym_data, sym_k, link_up, ctl_ready, dat_ready} !== 13'h0) begin
            fails++;
            $display("FAIL arst_immediate: got v=%b d=%h k=%b up=%b cr=%b dr=%b, want all 0",
                     sym_valid, sym_data, sym_k, link_up, ctl_ready, dat_ready);
        end
        repeat (3) tick();
        dat_data = 8'h5B;
        rst_n    = 1'b1;
        align_seq("arst_realign");
        to_slot(stray);
        tests++;
        if (dat_ready !== 1'b1) begin
            fails++;
            $display("FAIL arst_resume_ready: got %b, want 1", dat_ready);
        end
        tick();
        tests++;
        if (sym_valid !== 1'b1 || sym_data !== 8'h5B || sym_k !== 1'b0) begin
            fails++;
            $display("FAIL arst_resume_sym: got v=%b %h/K=%b, want v=1 5b/K=0", sym_valid,
                     sym_data, sym_k);
        end
        dat_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_idle();
        test_arbitration(7);
        test_link_drop();
        test_arbitration(10);
        test_data_latency();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/serdes_tx_sched.md
# serdes_tx_sched

Word-rate transmit scheduler for the 8b/10b serializer. It runs link bring-up by sending comma alignment symbols, then shares symbol slots between a control (K-character) requester and a data requester. When neither requester has a word, it fills the slot with idle commas. It also inserts periodic skip symbols for clock compensation. Its output feeds the 8b/10b encoder and serializer once per symbol slot.

## Interface
- `DATA_WIDTH`, 8, symbol payload width; only 8 is supported.
- `SYM_PERIOD`, 10, `i_Clk` cycles per symbol slot; must be ≥2.
- `ALIGN_COUNT`, 4, number of K28.5 commas sent during alignment; must be ≥1.
- `SKIP_INTERVAL`, 256, active slots per skip symbol; must be ≥2.
- `MAX_CTL_BURST`, 4, maximum consecutive control grants while data is waiting; must be ≥1.

Ports:
- `i_Clk` in 1: single clock. Reset is asynchronous, active-low.
- `i_Rst_n` in 1: asynchronous active-low reset.
- `i_Link_En` in 1: link enable.
- `i_Ctl_Valid` in 1, `i_Ctl_Data` in DATA_WIDTH, `o_Ctl_Ready` out 1: control requester; its words are sent as K-characters.
- `i_Dat_Valid` in 1, `i_Dat_Data` in DATA_WIDTH, `o_Dat_Ready` out 1: data requester; its words are sent as D-characters.
- `o_Sym_Valid` out 1: one-cycle strobe per issued symbol.
- `o_Sym_Data` out DATA_WIDTH: symbol byte.
- `o_Sym_K` out 1: 1 = K-character.
- `o_Link_Up` out 1: high in ACTIVE.

## Operation
- States:
  - OFF: no symbols issued.
  - ALIGN: issues ALIGN_COUNT commas (0xBC, K=1).
  - ACTIVE: normal traffic.
- State transitions:
  - OFF→ALIGN when `i_Link_En`=1 is sampled.
  - ALIGN→ACTIVE on the edge that issues the last comma.
  - Any state→OFF on the first edge where `i_Link_En`=0.
- Slot counter:
  - Counts 0..SYM_PERIOD-1 and wraps; forced to 0 on entry to ALIGN.
  - The cycle where the counter is 0 and `i_Link_En`=1 is the slot cycle.
- ACTIVE slot priority, highest first:
  1. Skip: emit 0x1C (K28.0, K=1); both readys low; no grant.
  2. Control: granted if `i_Ctl_Valid`, unless data is valid and the burst counter equals MAX_CTL_BURST.
  3. Data: granted if `i_Dat_Valid`.
  4. Idle: emit 0xBC (K=1).
- Readys:
  - Combinational.
  - High only in ACTIVE slot cycles, and only for the requester that would be granted.
  - A transfer occurs when valid & ready.
  - Requesters hold valid and data stable until accepted; readys never depend on each other.
- Burst counter:
  - Increments on a control grant while `i_Dat_Valid`=1.
  - Cleared on a data grant, or on any slot where `i_Dat_Valid`=0.
  - Saturates at MAX_CTL_BURST.
- Skip counter (when enabled): increments every ACTIVE slot. The slot where it equals SKIP_INTERVAL-1 is a skip slot, and the counter then clears to 0.
- Mid-operation disable: dropping `i_Link_En` aborts alignment or traffic. No grant is issued while it is low. Re-enabling restarts the full ALIGN sequence, and the skip and burst counters clear.

## Timing
- Reset values: all outputs 0, state OFF, all counters 0.
- `o_Sym_*` are registered from the slot cycle. `o_Sym_Valid` is high exactly one cycle, the cycle after the slot cycle, and `o_Sym_Data`/`o_Sym_K` are valid with it (held otherwise).
- Bring-up latency:
  - `i_Link_En` sampled high at edge N (OFF→ALIGN).
  - Slot cycle is N+1; first `o_Sym_Valid` at N+2.
  - Subsequent symbols follow every SYM_PERIOD cycles.
- `o_Link_Up` rises in the same cycle as the `o_Sym_Valid` of the last alignment comma. It falls the cycle after `i_Link_En`=0 is sampled.
- Accepted-word latency: valid&ready at slot cycle T → `o_Sym_Valid` with that word at T+1.
- Simultaneous events: a skip slot that coincides with pending requesters stalls both for one slot, with no data loss.

## Configuration
- `SERDES_SCHED_SKIP_EN`:
  - Defined: periodic K28.0 skip insertion every SKIP_INTERVAL active slots, as above.
  - Undefined: no skip counter is built, and no skip symbols are ever emitted. SKIP_INTERVAL is ignored.

## Structure
- Shared package `serdes_pkg` holds:
  - `K28_5` = 8'hBC and `K28_0` = 8'h1C.
  - State enum `sched_state_t` {OFF, ALIGN, ACTIVE}.
- Sub-module `sym_slot_timer`:
  - Slot counter with a synchronous restart input.
  - Output is the slot-cycle strobe.
- The scheduler instantiates `sym_slot_timer` once.

## Test plan
- Reset, then `i_Link_En`=1 with SYM_PERIOD=10, ALIGN_COUNT=4 → four 0xBC/K=1 strobes at cycles N+2, N+12, N+22, N+32; `o_Link_Up`=1 at N+32.
- ACTIVE, no requesters → 0xBC/K=1 every 10 cycles. With the macro on and SKIP_INTERVAL=4 → every 4th active symbol is 0x1C/K=1.
- Both requesters valid continuously, MAX_CTL_BURST=4 → symbol pattern C,C,C,C,D,C,C,C,C,D…; ctl symbols K=1, data symbols K=0 and byte-exact.
- Data word 0xA5 accepted in a slot cycle → 0xA5/K=0 the next cycle; `o_Dat_Ready` is high for exactly that one cycle.
- `i_Link_En` dropped during ALIGN after 2 commas → OFF with no further strobes; on re-enable, 4 fresh commas before `o_Link_Up`.
- Assert `i_Rst_n` low mid-traffic → all outputs 0 immediately (asynchronous); traffic resumes only after a new alignment.
